ifu_fetch_stage: RTL



---
 rtl/ifu_fetch_stage_pkg.sv | 49 ++++
 rtl/ifu_fetch_stage_npc_calc.sv | 46 ++++
 rtl/ifu_fetch_stage.sv | 58 +++++
 3 files changed

// File: rtl/ifu_fetch_stage_pkg.sv
// Shared MIPS opcode/funct/rt constants, reset defaults and the D-stage
// control-flow classifier used by the fetch stage, comparator and decoder.
package ifu_fetch_stage_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;

   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      CLS_SEQ,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_JREG
   } instr_class_e;

   // Anything not recognised here (including movz) falls through as sequential.
   function automatic instr_class_e classify(input logic [31:0] instr);
      logic [5:0] op;
      logic [4:0] rt;
      logic [5:0] funct;
      op    = instr[31:26];
      rt    = instr[20:16];
      funct = instr[5:0];
      if (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ)
         return CLS_BRANCH;
      if (op == OP_REGIMM && (rt == RT_BLTZ || rt == RT_BGEZ))
         return CLS_BRANCH;
      if (op == OP_J || op == OP_JAL)
         return CLS_JUMP;
      if (op == OP_SPECIAL && (funct == FN_JR || funct == FN_JALR))
         return CLS_JREG;
      return CLS_SEQ;
   endfunction

endpackage

// File: rtl/ifu_fetch_stage_npc_calc.sv
// Next-PC selection for the fetch stage, driven by the instruction held in D.
// Purely combinational; the redirect flag marks any non-sequential target.
module ifu_npc_calc
   import ifu_fetch_stage_pkg::*;
(
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_d,
   input  logic [31:0] pc_f,
   input  logic        cmp_taken_d,
   input  logic [31:0] rs_data_d,
   output logic [31:0] npc,
   output logic        redirect_d
);

   instr_class_e cls;
   logic [31:0]  branch_target;
   logic [31:0]  jump_target;

   assign cls           = classify(instr_d);
   assign branch_target = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
   assign jump_target   = {pc_d[31:28], instr_d[25:0], 2'b00};

   // jr/jalr targets pass through unaligned; misalignment is trapped downstream.
   always_comb begin
      npc        = pc_f + 32'd4;
      redirect_d = 1'b0;
      unique case (cls)
         CLS_BRANCH: begin
            if (cmp_taken_d) begin
               npc        = branch_target;
               redirect_d = 1'b1;
            end
         end
         CLS_JUMP: begin
            npc        = jump_target;
            redirect_d = 1'b1;
         end
         CLS_JREG: begin
            npc        = rs_data_d;
            redirect_d = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ifu_fetch_stage.sv
// Fetch stage with PC_F and the IF/ID register of the 5-stage MIPS pipeline.
// Define IFU_DELAY_SLOT_EN for architectural delay slots; otherwise the slot word is squashed.
module ifu_fetch_stage
   import ifu_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        cmp_taken_d,
   input  logic [31:0] rs_data_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        redirect_d
);

   logic [31:0] pc_f;
   logic [31:0] npc;
   logic [31:0] fetched_word;

   ifu_npc_calc u_npc_calc (
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc_f        (pc_f),
      .cmp_taken_d (cmp_taken_d),
      .rs_data_d   (rs_data_d),
      .npc         (npc),
      .redirect_d  (redirect_d)
   );

   assign imem_addr = pc_f;
   assign pc8_d     = pc_d + 32'd8;

`ifdef IFU_DELAY_SLOT_EN
   assign fetched_word = imem_rdata;
`else
   assign fetched_word = redirect_d ? NOP_WORD : imem_rdata;
`endif

   // A stall freezes both PC_F and IF/ID, so a pending redirect is simply re-evaluated next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f    <= RESET_PC;
         instr_d <= NOP_WORD;
         pc_d    <= RESET_PC;
      end else if (!stall) begin
         pc_f    <= npc;
         instr_d <= fetched_word;
         pc_d    <= pc_f;
      end
   end

endmodule
